// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART blocks.
// Holds the receiver state encoding, the oversampling ratio and the divisor calculation.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  localparam int OVERSAMPLE = 16;

  // Rounded clk-per-tick divisor: round(clock_mhz*1e6 / (baud*OVERSAMPLE)).
  function automatic int baud_div(input int clock_mhz, input int baud);
    longint num;
    longint den;
    num = longint'(clock_mhz) * 64'sd1_000_000;
    den = longint'(baud) * longint'(OVERSAMPLE);
    return int'((num + den / 2) / den);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// 16x oversampling tick generator: one-clk tick every DIV clocks.
// The clr input restarts the count so ticks can be phase-aligned to a line edge.
module uart_baud_tick #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver: 2-flop synchroniser, 16x oversampling with 3-sample majority vote,
// and a one-entry holding register with valid/ready handshake plus frame/overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCK_MHZ = 50,
  parameter int BAUD      = 115200,
  parameter int DIV       = baud_div(CLOCK_MHZ, BAUD)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun_err
);

  rx_state_t  state;
  logic       sync_p0;
  logic       rxd_s;
  logic       tick;
  logic       clr;
  logic [3:0] scnt;
  logic [2:0] bidx;
  logic [7:0] shreg;
  logic       s7;
  logic       s8;
  logic       decide;
  logic       bitval;

  function automatic logic majority(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Synchroniser: rxd is asynchronous, only rxd_s is used downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b1;
      rxd_s   <= 1'b1;
    end else begin
      sync_p0 <= rxd;
      rxd_s   <= sync_p0;
    end
  end

  // Holding the divider cleared while idle makes the first tick land DIV clk after the start edge.
  assign clr = (state == IDLE);

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

  assign decide = tick && (scnt == 4'd9) && (state != IDLE);
  assign bitval = majority(s7, s8, rxd_s);

  // Sample capture and shift register: pure data, no reset needed.
  always_ff @(posedge clk) begin
    if (tick && scnt == 4'd7) s7 <= rxd_s;
    if (tick && scnt == 4'd8) s8 <= rxd_s;
    if (decide && state == DATA) shreg <= {bitval, shreg[7:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      scnt        <= '0;
      bidx        <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (state != IDLE && tick) scnt <= scnt + 1'b1;

      case (state)
        IDLE: begin
          scnt <= '0;
          if (!rxd_s) state <= START;
        end
        START: begin
          if (decide) begin
            if (bitval) begin
              state <= IDLE;
            end else begin
              state <= DATA;
              bidx  <= '0;
            end
          end
        end
        DATA: begin
          if (decide) begin
            bidx <= bidx + 1'b1;
            if (bidx == 3'd7) state <= STOP;
          end
        end
        STOP: begin
          // Returning to IDLE mid stop bit lets the next start edge be caught early.
          if (decide) begin
            state <= IDLE;
            if (!bitval) begin
              frame_err <= 1'b1;
            end else if (!rx_valid || rx_ready) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
            end else begin
              overrun_err <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomised + directed bench for uart_rx with a queue-based scoreboard.
// A frame-level model predicts accepted bytes and error pulses; a monitor compares them.
module tb_uart_rx;

  logic       clk;
  logic       rst;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun_err;

  uart_rx dut (
    .clk         (clk),
    .rst         (rst),
    .rxd         (rxd),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_err   (frame_err),
    .overrun_err (overrun_err)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int passed = 0;
  int total  = 0;

  logic [7:0] bq[$];
  int         eq[$];
  logic       model_full = 1'b0;
  logic [7:0] mon_exp;
  int         mon_kind;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard monitor: sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid && rx_ready) begin
        if (bq.size() == 0) begin
          chk("spurious_byte", int'(rx_valid), 0);
        end else begin
          mon_exp = bq.pop_front();
          chk("rx_data", int'(rx_data), int'(mon_exp));
        end
      end
      if (frame_err || overrun_err) begin
        mon_kind = int'({overrun_err, frame_err});
        if (eq.size() == 0) chk("spurious_err", mon_kind, 0);
        else chk("err_kind", mon_kind, eq.pop_front());
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Frame-level model: stop=0 is a frame error (1); a good byte with a full,
  // unready holding register is an overrun (2); otherwise the byte is delivered.
  task automatic expect_frame(input logic [7:0] d, input logic stop);
    if (!stop) begin
      eq.push_back(1);
    end else if (model_full && !rx_ready) begin
      eq.push_back(2);
    end else begin
      bq.push_back(d);
      if (!rx_ready) model_full = 1'b1;
    end
  endtask

  task automatic send_bit(input logic v, input int period);
    rxd = v;
    cyc(period);
  endtask

  task automatic frame(input logic [7:0] d, input logic stop, input int period, input int gap);
    expect_frame(d, stop);
    send_bit(1'b0, period);
    for (int i = 0; i < 8; i++) send_bit(d[i], period);
    send_bit(stop, period);
    rxd = 1'b1;
    cyc(gap);
  endtask

  initial begin
    logic [7:0] pat;
    rst = 1'b1;
    rxd = 1'b1;
    rx_ready = 1'b1;
    cyc(3);
    chk("reset_rx_valid", int'(rx_valid), 0);
    chk("reset_rx_data", int'(rx_data), 0);
    chk("reset_frame_err", int'(frame_err), 0);
    chk("reset_overrun_err", int'(overrun_err), 0);
    rst = 1'b0;
    cyc(50);

    // Plain byte
    frame(8'hA5, 1'b1, 432, 100);
    chk("t1_drained", bq.size() + eq.size(), 0);

    // Short low glitch then a real byte
    rxd = 1'b0;
    cyc(100);
    rxd = 1'b1;
    cyc(600);
    frame(8'h3C, 1'b1, 432, 100);
    chk("t2_drained", bq.size() + eq.size(), 0);

    // Bad stop bit, one bit idle, then a good byte
    frame(8'h55, 1'b0, 432, 432);
    chk("t3_no_valid", int'(rx_valid), 0);
    frame(8'h0F, 1'b1, 432, 100);
    chk("t3_drained", bq.size() + eq.size(), 0);

    // Overrun with consumer stalled
    rx_ready = 1'b0;
    frame(8'h11, 1'b1, 432, 100);
    chk("t4_held_valid", int'(rx_valid), 1);
    chk("t4_held_data", int'(rx_data), 'h11);
    frame(8'h22, 1'b1, 432, 100);
    chk("t4_kept_valid", int'(rx_valid), 1);
    chk("t4_kept_data", int'(rx_data), 'h11);
    chk("t4_err_seen", eq.size(), 0);
    rx_ready = 1'b1;
    model_full = 1'b0;
    cyc(1);
    chk("t4_valid_drop", int'(rx_valid), 0);
    chk("t4_drained", bq.size() + eq.size(), 0);

    // Baud mismatch +/-3% plus random bytes at random rates in that window
    frame(8'h00, 1'b1, 419, 100);
    frame(8'hFF, 1'b1, 445, 100);
    frame(8'h5A, 1'b1, 419, 100);
    for (int k = 0; k < 3; k++) begin
      pat = 8'($urandom_range(0, 255));
      frame(pat, 1'b1, int'($urandom_range(419, 445)), 100);
    end
    chk("t5_drained", bq.size() + eq.size(), 0);

    // Reset mid-frame while a byte is held
    rx_ready = 1'b0;
    frame(8'h7E, 1'b1, 432, 100);
    chk("t6_held_valid", int'(rx_valid), 1);
    pat = 8'h81;
    send_bit(1'b0, 432);
    for (int i = 0; i < 4; i++) send_bit(pat[i], 432);
    rxd = pat[4];
    cyc(200);
    #3 rst = 1'b1;
    #1;
    chk("t6_rst_valid", int'(rx_valid), 0);
    chk("t6_rst_data", int'(rx_data), 0);
    chk("t6_rst_errs", int'({overrun_err, frame_err}), 0);
    bq.delete();
    model_full = 1'b0;
    rxd = 1'b1;
    rx_ready = 1'b1;
    cyc(5);
    rst = 1'b0;
    cyc(900);
    chk("t6_no_spurious", int'(rx_valid), 0);
    frame(8'h81, 1'b1, 432, 100);
    chk("t6_drained", bq.size() + eq.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
